core_cache_arbiter: RTL and testbench

//  Parametrised N-core front end to the single shared cache port.
//  - Accepts load/store requests from N_CORES cores.
//  - Grants one request at a time, round-robin, and forwards it to the cache.
//  - Routes the cache response back to the granted core; one transaction outstanding.
//  - Adds a response timeout with error return, which the single-core board never had.
//  - Sits between the N core instances and the cache on the board.

---
 rtl/core_cache_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_core_cache_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_cache_arbiter.sv
// core_cache_arbiter: round-robin front end that shares one cache port among
// N_CORES cores. One transaction is outstanding at a time. The response is
// routed back to the granted core, and a watchdog returns an error response
// if the cache stays silent for TIMEOUT cycles after it accepted the request.
module core_cache_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CORES-1:0]        req_valid,
    input  logic [N_CORES-1:0]        req_we,
    input  logic [N_CORES*ADDR_W-1:0] req_addr,
    input  logic [N_CORES*DATA_W-1:0] req_wdata,
    output logic [N_CORES-1:0]        req_ready,
    output logic [N_CORES-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      c_req_valid,
    output logic                      c_req_we,
    output logic [ADDR_W-1:0]         c_addr,
    output logic [DATA_W-1:0]         c_wdata,
    input  logic                      c_req_ready,
    input  logic                      c_rsp_valid,
    input  logic [DATA_W-1:0]         c_rsp_rdata,
    output logic                      stray_rsp
);

    localparam int IDX_W = $clog2(N_CORES);
    // The counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    gnt_q, gnt_d;
    logic [CNT_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                c_req_valid_q, c_req_valid_d;
    logic [N_CORES-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                stray_q, stray_d;

    logic                gnt_found;
    logic [IDX_W-1:0]    gnt_idx;
    logic [IDX_W:0]      scan_sum;
    logic [IDX_W-1:0]    next_ptr;

    // Round-robin search: first requesting core at or above rr_ptr, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_sum  = '0;
        for (int off = 0; off < N_CORES; off++) begin
            scan_sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (scan_sum >= (IDX_W+1)'(N_CORES)) begin
                scan_sum = scan_sum - (IDX_W+1)'(N_CORES);
            end
            if (!gnt_found && req_valid[scan_sum[IDX_W-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_sum[IDX_W-1:0];
            end
        end
    end

    // Accept pulse is combinational in IDLE and forced low while in reset.
    always_comb begin
        req_ready = '0;
        if (rst && (state_q == ST_IDLE) && gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Pointer to the core after the one being served, wrapping at N_CORES-1.
    always_comb begin
        next_ptr = gnt_q + IDX_W'(1);
        if (gnt_q == IDX_W'(N_CORES - 1)) begin
            next_ptr = '0;
        end
    end

    // Next-state and next-output logic for the IDLE -> REQ -> WAIT_RSP loop.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        gnt_d         = gnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        c_req_valid_d = c_req_valid_q;
        rsp_valid_d   = '0;
        rsp_rdata_d   = '0;
        rsp_err_d     = 1'b0;
        stray_d       = stray_q;

        unique case (state_q)
            ST_IDLE: begin
                if (c_rsp_valid) begin
                    stray_d = 1'b1;
                end
                if (gnt_found) begin
                    gnt_d         = gnt_idx;
                    we_d          = req_we[gnt_idx];
                    addr_d        = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
                    wdata_d       = req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                    c_req_valid_d = 1'b1;
                    state_d       = ST_REQ;
                end
            end
            ST_REQ: begin
                if (c_rsp_valid) begin
                    stray_d = 1'b1;
                end
                if (c_req_ready) begin
                    tmo_cnt_d     = '0;
                    c_req_valid_d = 1'b0;
                    state_d       = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
                // A real response beats a timeout landing in the same cycle.
                if (c_rsp_valid) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_rdata_d        = c_rsp_rdata;
                    rr_ptr_d           = next_ptr;
                    state_d            = ST_IDLE;
                end else if (tmo_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    rr_ptr_d           = next_ptr;
                    state_d            = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request fields and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= '0;
            gnt_q         <= '0;
            tmo_cnt_q     <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            c_req_valid_q <= 1'b0;
            rsp_valid_q   <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            stray_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            gnt_q         <= gnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            c_req_valid_q <= c_req_valid_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            stray_q       <= stray_d;
        end
    end

    assign c_req_valid = c_req_valid_q;
    assign c_req_we    = we_q;
    assign c_addr      = addr_q;
    assign c_wdata     = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign stray_rsp   = stray_q;

endmodule

// File: tb/tb_core_cache_arbiter.sv
// Bench for core_cache_arbiter: directed scenarios with literal expectations,
// then randomized cores and cache, all checked every cycle against a
// transaction-level reference model.
module tb_core_cache_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic            clk, rst;
    logic [N-1:0]    req_valid, req_we, req_ready, rsp_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, c_wdata, c_rsp_rdata;
    logic [AW-1:0]   c_addr;
    logic            rsp_err, c_req_valid, c_req_we, c_req_ready, c_rsp_valid, stray_rsp;

    int n_checks = 0;
    int n_errors = 0;
    int tk = 0;

    core_cache_arbiter #(.N_CORES(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .c_req_valid(c_req_valid), .c_req_we(c_req_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_req_ready(c_req_ready), .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
        .stray_rsp(stray_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tk++;
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // ---------------- transaction-level reference model ----------------
    bit            m_busy, m_acc, m_rsp_due, m_rsp_err, m_stray, m_we;
    int            m_own, m_rr, m_acc_cyc, m_cyc, m_rsp_core;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rsp_data;
    logic [N-1:0]  seen_ready, seen_rsp;

    always @(negedge clk) begin : model
        int g;
        logic [N-1:0] e_ready, e_rspv;
        if (!rst) begin
            m_busy = 0; m_acc = 0; m_own = 0; m_rr = 0; m_rsp_due = 0;
            m_rsp_err = 0; m_stray = 0; m_we = 0; m_addr = '0; m_wdata = '0;
        end
        g = -1;
        if (rst && !m_busy)
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
        e_ready = '0;
        if (g >= 0) e_ready[g] = 1'b1;
        e_rspv = '0;
        if (m_rsp_due) e_rspv[m_rsp_core] = 1'b1;

        chk("req_ready",   64'(req_ready),   64'(e_ready));
        chk("rsp_valid",   64'(rsp_valid),   64'(e_rspv));
        chk("rsp_rdata",   64'(rsp_rdata),   m_rsp_due ? 64'(m_rsp_data) : 64'd0);
        chk("rsp_err",     64'(rsp_err),     64'(m_rsp_due && m_rsp_err));
        chk("c_req_valid", 64'(c_req_valid), 64'(m_busy && !m_acc));
        chk("c_req_we",    64'(c_req_we),    64'(m_we));
        chk("c_addr",      64'(c_addr),      64'(m_addr));
        chk("c_wdata",     64'(c_wdata),     64'(m_wdata));
        chk("stray_rsp",   64'(stray_rsp),   64'(m_stray));

        seen_ready = req_ready;
        seen_rsp   = rsp_valid;
        m_rsp_due  = 0;

        if (rst) begin
            if (!m_busy) begin
                if (c_rsp_valid) m_stray = 1;
                if (g >= 0) begin
                    m_busy = 1; m_acc = 0; m_own = g;
                    m_we    = req_we[g];
                    m_addr  = req_addr[g*AW +: AW];
                    m_wdata = req_wdata[g*DW +: DW];
                end
            end else if (!m_acc) begin
                if (c_rsp_valid) m_stray = 1;
                if (c_req_ready) begin
                    m_acc = 1;
                    m_acc_cyc = m_cyc + 1;
                end
            end else if (c_rsp_valid || (m_cyc - m_acc_cyc == T - 1)) begin
                m_rsp_due  = 1;
                m_rsp_core = m_own;
                m_rsp_err  = !c_rsp_valid;
                m_rsp_data = c_rsp_valid ? c_rsp_rdata : '0;
                m_busy     = 0;
                m_rr       = (m_own + 1) % N;
            end
        end
        m_cyc++;
    end

    // ---------------- randomized core and cache drivers ----------------
    int out_st[N];

    task automatic rand_drive(input bit draining);
        for (int i = 0; i < N; i++) begin
            if (out_st[i] == 1 && seen_ready[i]) begin
                req_valid[i] = 1'b0;
                out_st[i] = 2;
            end else if (out_st[i] == 2 && seen_rsp[i]) begin
                out_st[i] = 0;
            end else if (out_st[i] == 0 && !draining && $urandom_range(3) == 0) begin
                req_valid[i] = 1'b1;
                req_we[i] = 1'($urandom_range(1));
                req_addr[i*AW +: AW]  = $urandom;
                req_wdata[i*DW +: DW] = $urandom;
                out_st[i] = 1;
            end
        end
        c_req_ready = draining ? 1'b1 : ($urandom_range(2) != 0);
        c_rsp_valid = ($urandom_range(3) == 0);
        c_rsp_rdata = $urandom;
    endtask

    function automatic bit any_out();
        bit r = 0;
        for (int i = 0; i < N; i++) if (out_st[i] != 0) r = 1;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[5];
        int ngr, n, t0, guard;
        bit prev_acc;

        rst = 1'b1;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        c_req_ready = 1'b0; c_rsp_valid = 1'b0; c_rsp_rdata = '0;
        for (int i = 0; i < N; i++) out_st[i] = 0;
        #1 rst = 1'b0;
        repeat (3) tick();
        chk("rst_c_req_valid", 64'(c_req_valid), 64'd0);
        chk("rst_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("rst_c_addr",      64'(c_addr),      64'd0);
        chk("rst_stray",       64'(stray_rsp),   64'd0);

        // Scenario: all four cores request continuously from reset.
        rst = 1'b1;
        req_valid = 4'hF; req_we = 4'b0101;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = 32'(256 * (i + 1));
            req_wdata[i*DW +: DW] = 32'(16 * (i + 1));
        end
        c_req_ready = 1'b1;
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 5; c++) begin
            #1;
            if (req_ready != '0) begin
                order[ngr] = oh2idx(req_ready);
                ngr++;
            end
            prev_acc = c_req_valid && c_req_ready;
            tick();
            c_rsp_valid = prev_acc;
            c_rsp_rdata = 32'hA000_0000 + 32'(c);
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) begin
            #1 prev_acc = c_req_valid && c_req_ready;
            tick();
            c_rsp_valid = prev_acc;
        end
        c_rsp_valid = 1'b0; c_req_ready = 1'b0;
        chk("grant_count", 64'(ngr), 64'd5);
        for (int k = 0; k < 5; k++) chk("grant_order", 64'(order[k]), 64'(k % 4));

        // Scenario: core1 reads 0x40, cache ready at once, data one cycle later.
        tick();
        req_valid = 4'b0010; req_we = '0; req_addr[1*AW +: AW] = 32'h40;
        t0 = tk;
        #1 chk("t1_req_ready", 64'(req_ready), 64'b0010);
        tick();
        req_valid = '0; c_req_ready = 1'b1;
        #1;
        chk("t1_c_req_valid", 64'(c_req_valid), 64'd1);
        chk("t1_c_addr",      64'(c_addr),      64'h40);
        chk("t1_c_we",        64'(c_req_we),    64'd0);
        tick();
        c_req_ready = 1'b0; c_rsp_valid = 1'b1; c_rsp_rdata = 32'hDEAD_BEEF;
        tick();
        c_rsp_valid = 1'b0; c_rsp_rdata = '0;
        #1;
        chk("t1_rsp_valid", 64'(rsp_valid), 64'b0010);
        chk("t1_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        chk("t1_rsp_err",   64'(rsp_err),   64'd0);
        chk("t1_latency",   64'(tk - t0 + 1), 64'd4);
        tick();
        chk("t1_rsp_pulse", 64'(rsp_valid), 64'd0);

        // Scenario: data response lands on the exact timeout cycle.
        tick();
        req_valid = 4'b0001; req_addr[0 +: AW] = 32'h200;
        tick();
        req_valid = '0; c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0;
        for (int k = 1; k < T; k++) begin
            tick();
            chk("t4_no_early_rsp", 64'(rsp_valid), 64'd0);
        end
        c_rsp_valid = 1'b1; c_rsp_rdata = 32'h1234_5678;
        tick();
        c_rsp_valid = 1'b0;
        #1;
        chk("t4_rsp_valid", 64'(rsp_valid), 64'b0001);
        chk("t4_rsp_err",   64'(rsp_err),   64'd0);
        chk("t4_rsp_rdata", 64'(rsp_rdata), 64'h1234_5678);
        tick();
        chk("t4_stray", 64'(stray_rsp), 64'd0);

        // Scenario: cache stalls 10 cycles; then answers just before timeout.
        tick();
        req_valid = 4'b1000; req_we = 4'b1000;
        req_addr[3*AW +: AW] = 32'h300; req_wdata[3*DW +: DW] = 32'hCAFE_F00D;
        tick();
        req_valid = '0; c_req_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("t5_c_req_valid", 64'(c_req_valid), 64'd1);
            chk("t5_c_addr",      64'(c_addr),      64'h300);
            chk("t5_c_wdata",     64'(c_wdata),     64'hCAFE_F00D);
            tick();
        end
        c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0;
        for (int k = 0; k < T - 2; k++) tick();
        c_rsp_valid = 1'b1; c_rsp_rdata = 32'h55;
        tick();
        c_rsp_valid = 1'b0; req_we = '0;
        #1;
        chk("t5_rsp_valid", 64'(rsp_valid), 64'b1000);
        chk("t5_rsp_err",   64'(rsp_err),   64'd0);

        // Scenario: cache never answers; then a late response arrives.
        tick();
        req_valid = 4'b0100; req_addr[2*AW +: AW] = 32'h80;
        tick();
        req_valid = '0; c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0;
        n = 0;
        while (rsp_valid == '0 && n < T + 5) begin
            tick();
            n++;
        end
        chk("t3_tmo_cycles", 64'(n), 64'(T));
        chk("t3_rsp_valid",  64'(rsp_valid), 64'b0100);
        chk("t3_rsp_err",    64'(rsp_err),   64'd1);
        chk("t3_rsp_rdata",  64'(rsp_rdata), 64'd0);
        tick();
        c_rsp_valid = 1'b1; c_rsp_rdata = 32'hBAD;
        tick();
        c_rsp_valid = 1'b0;
        #1 chk("t3_stray", 64'(stray_rsp), 64'd1);

        // Scenario: reset while waiting for the cache.
        tick();
        req_valid = 4'b0001; req_addr[0 +: AW] = 32'h500;
        tick();
        req_valid = '0; c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0;
        tick();
        rst = 1'b0;
        req_valid = 4'b1010; req_addr[1*AW +: AW] = 32'h11; req_addr[3*AW +: AW] = 32'h33;
        #1;
        chk("t6_c_req_valid", 64'(c_req_valid), 64'd0);
        chk("t6_rsp_valid",   64'(rsp_valid),   64'd0);
        chk("t6_stray",       64'(stray_rsp),   64'd0);
        chk("t6_req_ready",   64'(req_ready),   64'd0);
        chk("t6_c_addr",      64'(c_addr),      64'd0);
        tick();
        tick();
        rst = 1'b1;
        #1 chk("t6_rr_from_0", 64'(req_ready), 64'b0010);
        tick();
        req_valid = 4'b1000; c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0; c_rsp_valid = 1'b1; c_rsp_rdata = 32'h77;
        tick();
        c_rsp_valid = 1'b0;
        #1;
        chk("t6_rsp_core1",     64'(rsp_valid), 64'b0010);
        chk("t6_grant_with_rsp", 64'(req_ready), 64'b1000);
        tick();
        req_valid = '0; c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0; c_rsp_valid = 1'b1; c_rsp_rdata = 32'h99;
        tick();
        c_rsp_valid = 1'b0;
        #1 chk("t6_rsp_core3", 64'(rsp_valid), 64'b1000);
        tick();

        // Randomized traffic with one asynchronous reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (c == 1500) begin
                rst = 1'b0;
                req_valid = '0; c_req_ready = 1'b0; c_rsp_valid = 1'b0;
                for (int i = 0; i < N; i++) out_st[i] = 0;
                tick();
                tick();
                rst = 1'b1;
            end else begin
                rand_drive(1'b0);
            end
        end
        guard = 0;
        while (any_out() && guard < 300) begin
            tick();
            rand_drive(1'b1);
            guard++;
        end
        chk("drain_done", 64'(guard < 300), 64'd1);
        c_rsp_valid = 1'b0; c_req_ready = 1'b0;
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
